// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// apb_pkg : shared types, default widths and helpers for the APB slave banks
// Revision 1.0
// ============================================================================
package apb_pkg;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} apb_state_e;

  localparam int DEF_NUM_SLV     = 4;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_ADDR_WIDTH  = 8;
  localparam int DEF_DEPTH       = 32;
  localparam int DEF_WAIT_CYCLES = 0;

  // Callers zero-extend their select vector to 32 bits.
  function automatic bit onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_mem_bank.sv
`default_nettype none
// ============================================================================
// apb_mem_bank : DEPTH x DATA_WIDTH array, byte-strobed write, async read
// Revision 1.0
// ============================================================================
module apb_mem_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int AW         = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    we_i,
  input  logic [AW-1:0]           addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  in_range;

  // Guards non-power-of-two depths where addr_i can exceed the array.
  assign in_range = ({1'b0, addr_i} < (AW+1)'(DEPTH));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_q[w] <= '0;
      end
    end else if (we_i && in_range) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = in_range ? mem_q[addr_i] : '0;

endmodule
`default_nettype wire

// File: rtl/apb_multi_slave.sv
`default_nettype none
// ============================================================================
// apb_multi_slave : NUM_SLV memory-backed APB slaves behind one shared bus
// Revision 1.0
// ============================================================================
module apb_multi_slave
  import apb_pkg::*;
#(
  parameter int NUM_SLV     = DEF_NUM_SLV,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                    PCLK,
  input  logic                    RESETn,
  input  logic [NUM_SLV-1:0]      PSLEx,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDAR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BL    = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int WA    = ADDR_WIDTH - BL;
  localparam int MAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW    = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  apb_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [MAW-1:0]        addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BYTES-1:0]      strb_q, strb_d;
  logic [NUM_SLV-1:0]    psel_q, psel_d;
  logic [SW-1:0]         idx_q, idx_d;
  logic                  err_q, err_d;

  logic [WA-1:0]         word;
  logic                  misaligned, out_of_range, setup_err, setup, take, mem_we;
  logic [SW-1:0]         sel_idx;
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_SLV];

  assign word         = PADDAR[ADDR_WIDTH-1:BL];
  assign misaligned   = (PADDAR & ADDR_WIDTH'(BYTES - 1)) != '0;
  assign out_of_range = ({1'b0, word} >= (WA+1)'(DEPTH));
  assign setup_err    = !onehot(32'(PSLEx)) || misaligned || out_of_range;
  assign setup        = (|PSLEx) && !PENABLE;

  // Lowest set bit; only meaningful when the select is one-hot, otherwise err masks it.
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (PSLEx[i]) sel_idx = SW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    psel_d  = psel_q;
    idx_d   = idx_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    take    = 1'b0;
    case (state_q)
      IDLE: take = setup;
      ACCESS: begin
        if (PENABLE && (PSLEx == psel_q)) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            mem_we  = write_q && !err_q;
            state_d = IDLE;
          end
        end else begin
          // Abort: no write, no response; a coincident setup restarts at once.
          state_d = IDLE;
          take    = setup;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      state_d = ACCESS;
      cnt_d   = 4'(WAIT_CYCLES);
      addr_d  = word[MAW-1:0];
      write_d = PWRITE;
      wdata_d = PWDATA;
      strb_d  = PSTRB;
      psel_d  = PSLEx;
      idx_d   = sel_idx;
      err_d   = setup_err;
    end
  end

  always_ff @(posedge PCLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      psel_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      psel_q  <= psel_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  for (genvar g = 0; g < NUM_SLV; g++) begin : g_bank
    apb_mem_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (MAW)
    ) u_bank (
      .clk_i   (PCLK),
      .rst_ni  (RESETn),
      .we_i    (mem_we && (idx_q == SW'(g))),
      .addr_i  (addr_q),
      .wdata_i (wdata_q),
      .wstrb_i (strb_q),
      .rdata_o (bank_rdata[g])
    );
  end

  assign PREADY  = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign PSLVERR = PREADY && err_q;
  assign PRDATA  = (PREADY && !write_q && !err_q) ? bank_rdata[idx_q] : '0;

endmodule
`default_nettype wire

// File: doc/apb_multi_slave.md
# apb_multi_slave

Parametrised successor to the single `AMBA_APB` slave: `NUM_SLV` independent memory-backed APB slaves behind one shared APB bus, selected by a one-hot `PSLEx` vector. Adds the following over the single slave:
- byte strobes (`PSTRB`);
- configurable wait states;
- `PSLVERR` for out-of-range, misaligned and multi-select accesses.

Sits under `apb_tb_top` in place of `AMBA_APB`, driven by the existing `apb_inf` (widened per parameters).

## Interface
Parameters:
- `NUM_SLV`, default 4: number of slave banks, which is also the `PSLEx` width.
- `DATA_WIDTH`, default 32: bus width; must be 8, 16 or 32.
- `ADDR_WIDTH`, default 8: byte address width.
- `DEPTH`, default 32: words per bank; must satisfy `DEPTH <= 2**(ADDR_WIDTH-BL)`.
- `WAIT_CYCLES`, default 0: `PREADY`-low cycles inserted in each access phase (0..15).

Derived: `BYTES = DATA_WIDTH/8`, `BL = $clog2(BYTES)`.

Ports:
- `PCLK`  in  1  clock. One clock; all state is on the rising edge.
- `RESETn`  in  1  reset, asynchronous, active-low.
- `PSLEx`  in  `NUM_SLV`  slave select, expected one-hot.
- `PENABLE`  in  1  access-phase strobe.
- `PWRITE`  in  1  1 = write, 0 = read.
- `PADDAR`  in  `ADDR_WIDTH`  byte address.
- `PWDATA`  in  `DATA_WIDTH`  write data.
- `PSTRB`  in  `BYTES`  write byte enables (ignored on reads).
- `PRDATA`  out  `DATA_WIDTH`  read data.
- `PREADY`  out  1  transfer completion.
- `PSLVERR`  out  1  error, valid only while `PREADY`=1.

## Operation
- **FSM states:** `IDLE`, `ACCESS`.
- **`IDLE` → `ACCESS`:** taken at an edge where `|PSLEx`=1 and `PENABLE`=0 (setup phase). That edge latches:
  - address, write flag, data and strobes;
  - the select index;
  - `err`;
  - `cnt` = `WAIT_CYCLES`.
- **`err` is set when any of these hold:**
  - `PSLEx` is not one-hot;
  - `PADDAR[BL-1:0]` != 0;
  - `PADDAR >> BL` >= `DEPTH`.
- **`ACCESS`, edge with `PSLEx` still equal to the latched select and `PENABLE`=1:**
  - If `cnt` != 0: decrement `cnt`.
  - Otherwise, complete the transfer:
    - Write with no `err`: update bytes `i` of bank[sel][word] where `PSTRB[i]`=1.
    - Read: no state change.
    - Next state is `IDLE`.
- **`ACCESS` abort:** an edge where `PENABLE`=0, or where `PSLEx` differs from the latched select, aborts to `IDLE`. There is no write and no response. If that same edge is a valid setup, it is taken directly, with a fresh latch and `ACCESS`.
- **Outputs are combinational from registers only, never from inputs:**
  - `PREADY` = (`state`==`ACCESS` && `cnt`==0).
  - `PSLVERR` = `PREADY` && `err`.
  - `PRDATA` = bank[sel][word] when `PREADY` && !`PWRITE_q` && !`err`; otherwise 0.
- **Banks:** each is `DEPTH` x `DATA_WIDTH`, all cleared to 0 on reset. Banks are fully independent.

## Timing
- **Reset values:** `PREADY`=0, `PSLVERR`=0, `PRDATA`=0, state `IDLE`, `cnt`=0, all memory 0.
- **Transfer latency:** one transfer is 2+`WAIT_CYCLES` cycles, setup cycle included. `PREADY` is high for exactly one cycle, the last one.
- **Back-to-back:** a setup phase may immediately follow the completion cycle, with no idle cycle required. Sustained throughput is one transfer per 2+`WAIT_CYCLES` cycles.
- **Write visibility:** the write commits at the completion edge. A read of the same word in the next transfer returns the new data.
- **Errored writes:** `PSTRB`=0 on a write completes normally and changes nothing. An errored write never modifies any bank.
- **Reset mid-transfer:** `RESETn` low at any point forces `IDLE` and zeroes the outputs and memory asynchronously. No partial write survives.

## Structure
- **Add to `apb_pkg`:**
  - `typedef enum logic {IDLE, ACCESS} apb_state_e`;
  - `localparam` defaults for widths;
  - a `function automatic bit onehot(...)` helper for the select check.
- **Sub-module `apb_mem_bank`:** one `DEPTH` x `DATA_WIDTH` array with a byte-strobed write port, an async-reset clear and a combinational read port. It is instantiated `NUM_SLV` times in a generate loop.
- **Top level:** contains the FSM, wait counter, error decode and read mux.
- **Size:** about 200 lines of RTL in total.

## Test plan
All scenarios use `NUM_SLV`=4, `DATA_WIDTH`=32, `ADDR_WIDTH`=8, `DEPTH`=32.
- **Basic write/read, `WAIT_CYCLES`=0:** write `0xDEADBEEF` to `PADDAR`=0x10, `PSLEx`=4'b0010, then read the same location.
  - Write: `PREADY` high in cycle 2, `PSLVERR`=0.
  - Read: `PRDATA`=`0xDEADBEEF`, and the same address in the other banks reads 0.
- **Strobed write, `WAIT_CYCLES`=2:** fill with `0x11223344`, then write `0xAABBCCDD` with `PSTRB`=4'b0101.
  - Readback = `0x11BB33DD`.
  - `PREADY` is low for 2 access cycles and high on the 4th cycle.
- **Error cases:** addresses `0x80` (out of range), `0x06` (misaligned), and `PSLEx`=4'b0011.
  - Each gives `PREADY`=1 with `PSLVERR`=1 and `PRDATA`=0.
  - Memory is unchanged.
- **Back-to-back transfers:** 8 alternating writes and reads with no idle cycles, `WAIT_CYCLES`=0.
  - All complete in 16 cycles.
  - Every read returns the immediately preceding write.
- **Reset and abort:**
  - Assert `RESETn`=0 during the access phase of a write of `0x12345678`: no write occurs, outputs are 0 immediately, and a later read returns 0.
  - Drop `PENABLE` mid-wait: `PREADY` is never asserted, and the next transfer completes normally.
